// File: rtl/avalon_mem_slave_if.sv
// Avalon-MM data-port bundle between the processor (master) and the memory slave.
// Handshake: a transfer is requested while Read or Write is high and completes in
// the first cycle in which Waitreq is low; Addr, WrData and ByteEn are held stable
// for as long as the request is held.
interface avalon_mem_slave_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 16
);
  logic                  Read;
  logic                  Write;
  logic [ADDR_W-1:0]     Addr;
  logic [DATA_W-1:0]     WrData;
  logic [DATA_W/8-1:0]   ByteEn;
  logic [DATA_W-1:0]     RdData;
  logic                  Waitreq;
  logic                  AccErr;

  modport master (
    output Read, Write, Addr, WrData, ByteEn,
    input  RdData, Waitreq, AccErr
  );

  modport slave (
    input  Read, Write, Addr, WrData, ByteEn,
    output RdData, Waitreq, AccErr
  );
endinterface

// File: rtl/avalon_mem_slave.sv
// Avalon-MM data-memory slave with fixed (optionally random-extended) wait states,
// byte enables, a base-address window and access-error flagging.
// Optional feature macro: WAIT_RAND_EN adds an 8-bit LFSR-driven extra wait per transfer.
// dbg_state exposes the FSM state (0 = IDLE, 1 = WAIT).
module avalon_mem_slave #(
  parameter int         DATA_W      = 16,
  parameter int         ADDR_W      = 16,
  parameter int         DEPTH       = 256,
  parameter int         BASE_ADDR   = 0,
  parameter int         WAIT_CYCLES = 1,
  parameter int         RAND_MASK   = 3,
  parameter logic [7:0] LFSR_SEED   = 8'hA5
) (
  input  logic              Clock,
  input  logic              Resetn,
  avalon_mem_slave_if.slave bus,
  output logic              dbg_state
);

  localparam int NB    = DATA_W / 8;
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic {S_IDLE = 1'b0, S_WAIT = 1'b1} state_t;

  state_t               state, state_n;
  logic [8:0]           cnt, cnt_n;
  logic [8:0]           w;
  logic                 req;
  logic                 in_range;
  logic [IDX_W-1:0]     idx;
  logic                 start;
  logic                 complete;
  logic                 abort;
  logic [DATA_W-1:0]    mem [DEPTH];

  assign req      = bus.Read | bus.Write;
  assign in_range = (int'(bus.Addr) >= BASE_ADDR) && (int'(bus.Addr) < BASE_ADDR + DEPTH);
  assign idx      = IDX_W'(int'(bus.Addr) - BASE_ADDR);
  assign start    = Resetn && (state == S_IDLE) && req;
  assign dbg_state = state;

`ifdef WAIT_RAND_EN
  logic [7:0] lfsr;

  // LFSR (taps 8,6,5,4) advances once per transfer start.
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      lfsr <= LFSR_SEED;
    end else if (start) begin
      lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
    end
  end

  assign w = 9'(WAIT_CYCLES) + {1'b0, lfsr & 8'(RAND_MASK)};
`else
  // Random-wait parameters have no effect in this build; folded into an unused tie-off.
  logic unused_cfg;
  assign unused_cfg = ^{LFSR_SEED, 8'(RAND_MASK)};
  assign w = 9'(WAIT_CYCLES);
`endif

  // FSM state and wait counter registers.
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state <= S_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
    end
  end

  // Next-state, wait counter and handshake outputs.
  always_comb begin
    state_n     = state;
    cnt_n       = cnt;
    bus.Waitreq = 1'b0;
    complete    = 1'b0;
    abort       = 1'b0;
    if (!Resetn) begin
      bus.Waitreq = 1'b1;
    end else begin
      case (state)
        S_IDLE: begin
          if (req) begin
            if (w == '0) begin
              complete = 1'b1;
            end else begin
              bus.Waitreq = 1'b1;
              cnt_n       = w - 9'd1;
              state_n     = S_WAIT;
            end
          end
        end
        S_WAIT: begin
          if (!req) begin
            // Master dropped the request mid-transfer: abandon it and flag it.
            abort   = 1'b1;
            cnt_n   = '0;
            state_n = S_IDLE;
          end else if (cnt != '0) begin
            bus.Waitreq = 1'b1;
            cnt_n       = cnt - 9'd1;
          end else begin
            complete = 1'b1;
            state_n  = S_IDLE;
          end
        end
        default: state_n = S_IDLE;
      endcase
    end
  end

  // Read data and error flag are combinational in the completion cycle.
  always_comb begin
    bus.RdData = '0;
    if (complete && bus.Read && !bus.Write && in_range) begin
      bus.RdData = mem[idx];
    end
    bus.AccErr = abort | (complete & (~in_range | (bus.Read & bus.Write)));
  end

  // Memory array: cleared on reset, byte-masked write at the completing edge.
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (complete && bus.Write && in_range) begin
      for (int b = 0; b < NB; b++) begin
        if (bus.ByteEn[b]) begin
          mem[idx][8*b +: 8] <= bus.WrData[8*b +: 8];
        end
      end
    end
  end

endmodule
